// File: rtl/sc_useq_microsequencer.sv
// sc_useq_microsequencer: loadable microcode control unit for the uDATAPATH (IDLE/RUN/DONE with step watchdog).
// Optional feature macro: SC_USEQ_SINGLESTEP_EN adds SC_USEQ_step_InHigh to gate microword execution.
module sc_useq_microsequencer #(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int ADDRWIDTH_USEQ                 = 5,
  parameter int MAX_STEPS                      = 1024,
  localparam int UW = 3 + ADDRWIDTH_USEQ + 2*DATAWIDTH_DECODER_SELECTION + 2*DATAWIDTH_MUX_SELECTION
                      + DATAWIDTH_ALU_SELECTION + 2 + DATAWIDTH_REGSHIFTER_SELECTION
) (
  input  logic                                      SC_USEQ_CLOCK_50,
  input  logic                                      SC_USEQ_RESET_InHigh,
  input  logic                                      SC_USEQ_start_InHigh,
`ifdef SC_USEQ_SINGLESTEP_EN
  input  logic                                      SC_USEQ_step_InHigh,
`endif
  input  logic                                      SC_USEQ_ucodewrite_InHigh,
  input  logic [ADDRWIDTH_USEQ-1:0]                 SC_USEQ_ucodeaddr_InBUS,
  input  logic [UW-1:0]                             SC_USEQ_ucodedata_InBUS,
  input  logic                                      SC_USEQ_overflow_InLow,
  input  logic                                      SC_USEQ_carry_InLow,
  input  logic                                      SC_USEQ_negative_InLow,
  input  logic                                      SC_USEQ_zero_InLow,
  output logic                                      SC_USEQ_busy_OutHigh,
  output logic                                      SC_USEQ_done_OutHigh,
  output logic                                      SC_USEQ_error_OutHigh,
  output logic [ADDRWIDTH_USEQ-1:0]                 SC_USEQ_pc_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_USEQ_decoderclearselection_OutBUS,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_USEQ_decoderloadselection_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_USEQ_muxselectionBUSA_OutBUS,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_USEQ_muxselectionBUSB_OutBUS,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_USEQ_aluselection_OutBUS,
  output logic                                      SC_USEQ_regSHIFTERclear_OutLow,
  output logic                                      SC_USEQ_regSHIFTERload_OutLow,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_USEQ_regSHIFTERshiftselection_OutLow
);

  localparam int DEC   = DATAWIDTH_DECODER_SELECTION;
  localparam int MUX   = DATAWIDTH_MUX_SELECTION;
  localparam int ALU   = DATAWIDTH_ALU_SELECTION;
  localparam int REGSH = DATAWIDTH_REGSHIFTER_SELECTION;
  localparam int AW    = ADDRWIDTH_USEQ;
  localparam int DEPTH = 1 << AW;
  localparam int SW    = $clog2(MAX_STEPS + 1);

  // Microword field positions, LSB upward
  localparam int SHSEL_LSB  = 0;
  localparam int SHLD_BIT   = REGSH;
  localparam int SHCLR_BIT  = REGSH + 1;
  localparam int ALU_LSB    = REGSH + 2;
  localparam int MUXB_LSB   = ALU_LSB + ALU;
  localparam int MUXA_LSB   = MUXB_LSB + MUX;
  localparam int DECLD_LSB  = MUXA_LSB + MUX;
  localparam int DECCLR_LSB = DECLD_LSB + DEC;
  localparam int TGT_LSB    = DECCLR_LSB + DEC;
  localparam int COND_LSB   = TGT_LSB + AW;

  localparam logic [2:0]    COND_HALT = 3'd7;
  localparam logic [SW-1:0] STEP_LIM  = SW'(MAX_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic [UW-1:0] mem_q [DEPTH];

  logic [UW-1:0] uword_s;
  logic [2:0]    cond_s;
  logic [AW-1:0] target_s;
  logic          exec_s;
  logic          take_branch_s;
  logic [SW-1:0] steps_inc_s;

  assign uword_s     = mem_q[pc_q];
  assign cond_s      = uword_s[COND_LSB +: 3];
  assign target_s    = uword_s[TGT_LSB +: AW];
  assign steps_inc_s = steps_q + SW'(1);

`ifdef SC_USEQ_SINGLESTEP_EN
  assign exec_s = (state_q == ST_RUN) && SC_USEQ_step_InHigh;
`else
  assign exec_s = (state_q == ST_RUN);
`endif

  // Microcode store: writable only while idle, never cleared by reset
  always_ff @(posedge SC_USEQ_CLOCK_50) begin
    if (SC_USEQ_ucodewrite_InHigh && (state_q == ST_IDLE)) begin
      mem_q[SC_USEQ_ucodeaddr_InBUS] <= SC_USEQ_ucodedata_InBUS;
    end
  end

  // Branch decision; flags are active low, so 0 means the condition holds
  always_comb begin
    take_branch_s = 1'b0;
    case (cond_s)
      3'd1:    take_branch_s = 1'b1;
      3'd2:    take_branch_s = ~SC_USEQ_zero_InLow;
      3'd3:    take_branch_s = ~SC_USEQ_negative_InLow;
      3'd4:    take_branch_s = ~SC_USEQ_carry_InLow;
      3'd5:    take_branch_s = ~SC_USEQ_overflow_InLow;
      3'd6:    take_branch_s = SC_USEQ_zero_InLow;
      default: take_branch_s = 1'b0;
    endcase
  end

  // Sequencer next-state: start handshake, pc update, halt and watchdog
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    steps_d = steps_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (SC_USEQ_start_InHigh) begin
          state_d = ST_RUN;
          pc_d    = {AW{1'b0}};
          steps_d = {SW{1'b0}};
          busy_d  = 1'b1;
          error_d = 1'b0;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (exec_s) begin
          steps_d = steps_inc_s;
          if (cond_s == COND_HALT) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (steps_inc_s >= STEP_LIM) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (take_branch_s) begin
            pc_d    = target_s;
          end else begin
            pc_d    = pc_q + AW'(1);
          end
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered status flags
  always_ff @(posedge SC_USEQ_CLOCK_50) begin
    if (SC_USEQ_RESET_InHigh) begin
      state_q <= ST_IDLE;
      pc_q    <= {AW{1'b0}};
      steps_q <= {SW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign SC_USEQ_busy_OutHigh  = busy_q;
  assign SC_USEQ_done_OutHigh  = done_q;
  assign SC_USEQ_error_OutHigh = error_q;
  assign SC_USEQ_pc_OutBUS     = pc_q;

  // Datapath controls: live microword fields while executing, safe hold values otherwise
  always_comb begin
    if (exec_s) begin
      SC_USEQ_decoderclearselection_OutBUS    = uword_s[DECCLR_LSB +: DEC];
      SC_USEQ_decoderloadselection_OutBUS     = uword_s[DECLD_LSB +: DEC];
      SC_USEQ_muxselectionBUSA_OutBUS         = uword_s[MUXA_LSB +: MUX];
      SC_USEQ_muxselectionBUSB_OutBUS         = uword_s[MUXB_LSB +: MUX];
      SC_USEQ_aluselection_OutBUS             = uword_s[ALU_LSB +: ALU];
      SC_USEQ_regSHIFTERclear_OutLow          = uword_s[SHCLR_BIT];
      SC_USEQ_regSHIFTERload_OutLow           = uword_s[SHLD_BIT];
      SC_USEQ_regSHIFTERshiftselection_OutLow = uword_s[SHSEL_LSB +: REGSH];
    end else begin
      SC_USEQ_decoderclearselection_OutBUS    = {DEC{1'b0}};
      SC_USEQ_decoderloadselection_OutBUS     = {DEC{1'b0}};
      SC_USEQ_muxselectionBUSA_OutBUS         = {MUX{1'b0}};
      SC_USEQ_muxselectionBUSB_OutBUS         = {MUX{1'b0}};
      SC_USEQ_aluselection_OutBUS             = {ALU{1'b0}};
      SC_USEQ_regSHIFTERclear_OutLow          = 1'b1;
      SC_USEQ_regSHIFTERload_OutLow           = 1'b1;
      SC_USEQ_regSHIFTERshiftselection_OutLow = {REGSH{1'b1}};
    end
  end

endmodule

// File: tb/tb_sc_useq_microsequencer.sv
// Bench for sc_useq_microsequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_sc_useq_microsequencer;
  localparam int AW    = 5;
  localparam int UW    = 28;
  localparam int DEPTH = 32;
  localparam int MAXS  = 16;
`ifdef SC_USEQ_SINGLESTEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  typedef struct {
    logic [2:0] cond;
    logic [4:0] tgt;
    logic [2:0] dclr;
    logic [2:0] dld;
    logic [2:0] ma;
    logic [2:0] mb;
    logic [3:0] alu;
    logic       shclr_n;
    logic       shld_n;
    logic [1:0] shsel;
  } uw_t;

  logic          clk = 1'b0;
  logic          rst, start, wr, step_in;
  logic [AW-1:0] waddr;
  logic [UW-1:0] wdata;
  logic          ovf_n, cy_n, neg_n, z_n;
  logic          busy, done, err;
  logic [AW-1:0] pc;
  logic [2:0]    dclr, dld, ma, mb;
  logic [3:0]    alu;
  logic          shclr_n, shld_n;
  logic [1:0]    shsel;

  uw_t wr_uw;
  int  n_pass = 0;
  int  n_total = 0;

  int  m_mode;
  int  m_pc;
  int  m_steps;
  bit  m_err;
  bit  m_valid = 1'b0;
  uw_t m_mem [DEPTH];

  always #5 clk = ~clk;

  sc_useq_microsequencer #(.MAX_STEPS(MAXS)) dut (
    .SC_USEQ_CLOCK_50                       (clk),
    .SC_USEQ_RESET_InHigh                   (rst),
    .SC_USEQ_start_InHigh                   (start),
`ifdef SC_USEQ_SINGLESTEP_EN
    .SC_USEQ_step_InHigh                    (step_in),
`endif
    .SC_USEQ_ucodewrite_InHigh              (wr),
    .SC_USEQ_ucodeaddr_InBUS                (waddr),
    .SC_USEQ_ucodedata_InBUS                (wdata),
    .SC_USEQ_overflow_InLow                 (ovf_n),
    .SC_USEQ_carry_InLow                    (cy_n),
    .SC_USEQ_negative_InLow                 (neg_n),
    .SC_USEQ_zero_InLow                     (z_n),
    .SC_USEQ_busy_OutHigh                   (busy),
    .SC_USEQ_done_OutHigh                   (done),
    .SC_USEQ_error_OutHigh                  (err),
    .SC_USEQ_pc_OutBUS                      (pc),
    .SC_USEQ_decoderclearselection_OutBUS   (dclr),
    .SC_USEQ_decoderloadselection_OutBUS    (dld),
    .SC_USEQ_muxselectionBUSA_OutBUS        (ma),
    .SC_USEQ_muxselectionBUSB_OutBUS        (mb),
    .SC_USEQ_aluselection_OutBUS            (alu),
    .SC_USEQ_regSHIFTERclear_OutLow         (shclr_n),
    .SC_USEQ_regSHIFTERload_OutLow          (shld_n),
    .SC_USEQ_regSHIFTERshiftselection_OutLow(shsel)
  );

  function automatic logic [UW-1:0] pack(uw_t u);
    return {u.cond, u.tgt, u.dclr, u.dld, u.ma, u.mb, u.alu, u.shclr_n, u.shld_n, u.shsel};
  endfunction

  function automatic uw_t mk(int c, int t, int a);
    uw_t u;
    u.cond = 3'(c);   u.tgt = 5'(t);     u.alu = 4'(a);
    u.dclr = 3'(a);   u.dld = 3'(a + 1); u.ma = 3'(a + 2); u.mb = 3'(a + 3);
    u.shclr_n = a[0]; u.shld_n = a[1];   u.shsel = 2'(a);
    return u;
  endfunction

  function automatic uw_t rnd_uw();
    uw_t u;
    u.cond = 3'($urandom_range(0, 7)); u.tgt = 5'($urandom);
    u.dclr = 3'($urandom); u.dld = 3'($urandom); u.ma = 3'($urandom); u.mb = 3'($urandom);
    u.alu = 4'($urandom); u.shclr_n = 1'($urandom); u.shld_n = 1'($urandom); u.shsel = 2'($urandom);
    return u;
  endfunction

  function automatic bit taken(uw_t w);
    case (w.cond)
      3'd1:    return 1'b1;
      3'd2:    return z_n == 1'b0;
      3'd3:    return neg_n == 1'b0;
      3'd4:    return cy_n == 1'b0;
      3'd5:    return ovf_n == 1'b0;
      3'd6:    return z_n == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: advances one clock of the sequencer per the microprogram rules
  always @(posedge clk) begin
    uw_t w;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_steps = 0; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode == 0) begin
        if (wr) m_mem[waddr] = wr_uw;
        if (start) begin
          m_mode = 1; m_pc = 0; m_steps = 0; m_err = 1'b0;
        end
      end else if (m_mode == 1) begin
        if (!SS || step_in) begin
          w = m_mem[m_pc];
          m_steps = m_steps + 1;
          if (w.cond == 3'd7) m_mode = 2;
          else if (m_steps >= MAXS) begin m_mode = 2; m_err = 1'b1; end
          else if (taken(w)) m_pc = int'(w.tgt);
          else m_pc = (m_pc + 1) % DEPTH;
        end
      end else begin
        m_mode = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    uw_t w;
    bit  ex;
    if (m_valid) begin
      w  = m_mem[m_pc];
      ex = (m_mode == 1) && (!SS || step_in);
      chk("busy",  32'(busy), 32'(m_mode == 1));
      chk("done",  32'(done), 32'(m_mode == 2));
      chk("error", 32'(err),  32'(m_err));
      if (m_mode == 1) chk("pc", 32'(pc), 32'(m_pc));
      chk("decclr", 32'(dclr),    ex ? 32'(w.dclr) : 32'd0);
      chk("decld",  32'(dld),     ex ? 32'(w.dld) : 32'd0);
      chk("muxa",   32'(ma),      ex ? 32'(w.ma) : 32'd0);
      chk("muxb",   32'(mb),      ex ? 32'(w.mb) : 32'd0);
      chk("alu",    32'(alu),     ex ? 32'(w.alu) : 32'd0);
      chk("shclr",  32'(shclr_n), ex ? 32'(w.shclr_n) : 32'd1);
      chk("shld",   32'(shld_n),  ex ? 32'(w.shld_n) : 32'd1);
      chk("shsel",  32'(shsel),   ex ? 32'(w.shsel) : 32'd3);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic load(int a, uw_t u);
    wr = 1'b1; waddr = 5'(a); wdata = pack(u); wr_uw = u;
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int i;
    i = 0;
    while (done !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    if (i >= 200) begin
      n_total++;
      $display("FAIL %s timeout waiting for done, got busy=%0b expected done=1", nm, busy);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; wr = 1'b0; step_in = 1'b1; waddr = '0; wdata = '0; wr_uw = mk(7, 0, 0);
    ovf_n = 1'b1; cy_n = 1'b1; neg_n = 1'b1; z_n = 1'b1;
    @(negedge clk); #2;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err),  32'd0);
    chk("rst_pc",   32'(pc),   32'd0);
    chk("rst_shsel", 32'(shsel), 32'd3);
    for (int i = 0; i < DEPTH; i++) load(i, mk(7, 0, 0));

    // Two-word program: ALU 1 then halt
    load(0, mk(0, 0, 1)); load(1, mk(7, 0, 0));
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy0", 32'(busy), 32'd1); chk("t1_alu0", 32'(alu), 32'd1);
    tick();
    chk("t1_busy1", 32'(busy), 32'd1); chk("t1_alu1", 32'(alu), 32'd0); chk("t1_pc1", 32'(pc), 32'd1);
    tick();
    chk("t1_done", 32'(done), 32'd1); chk("t1_busy2", 32'(busy), 32'd0); chk("t1_err", 32'(err), 32'd0);
    tick();
    chk("t1_done_end", 32'(done), 32'd0);

    // Conditional branch on zero flag
    load(0, mk(2, 5, 2)); load(5, mk(7, 0, 5)); load(1, mk(7, 0, 9));
    z_n = 1'b0; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t2_taken_pc", 32'(pc), 32'd5); chk("t2_taken_alu", 32'(alu), 32'd5);
    wait_done("t2a"); tick();
    z_n = 1'b1; start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t2_fall_pc", 32'(pc), 32'd1); chk("t2_fall_alu", 32'(alu), 32'd9);
    wait_done("t2b"); tick();

    // Watchdog on an infinite loop
    load(0, mk(1, 0, 3));
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) break;
      if (busy === 1'b1) n++;
      tick();
    end
    chk("t3_run_cycles", 32'(n), 32'd16);
    chk("t3_err", 32'(err), 32'd1);
    tick();
    chk("t3_err_sticky", 32'(err), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_err_clr", 32'(err), 32'd0);
    wait_done("t3"); tick();

    // Writes during RUN are dropped; reset mid-run keeps the program
    for (int i = 0; i < 4; i++) load(i, mk(0, 0, i + 1));
    load(4, mk(1, 4, 6));
    start = 1'b1; tick(); start = 1'b0;
    wr = 1'b1; waddr = 5'd3; wr_uw = mk(0, 0, 15); wdata = pack(wr_uw);
    tick(); wr = 1'b0;
    tick(); tick(); tick();
    chk("t4_pc4", 32'(pc), 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_rst_busy", 32'(busy), 32'd0); chk("t4_rst_alu", 32'(alu), 32'd0);
    chk("t4_rst_shclr", 32'(shclr_n), 32'd1);
    load(4, mk(7, 0, 6));
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("t4_pc3", 32'(pc), 32'd3); chk("t4_mem3_kept", 32'(alu), 32'd4);
    wait_done("t4"); tick();

    // pc wrap 31 -> 0, start held high through the run
    load(0, mk(6, 31, 1)); load(31, mk(0, 0, 2)); load(1, mk(7, 0, 3));
    z_n = 1'b1; start = 1'b1; tick();
    tick();
    chk("t5_pc31", 32'(pc), 32'd31);
    z_n = 1'b0; tick();
    chk("t5_wrap", 32'(pc), 32'd0);
    tick();
    chk("t5_pc1", 32'(pc), 32'd1);
    tick();
    chk("t5_done", 32'(done), 32'd1);
    start = 1'b0; z_n = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done === 1'b1) n++;
    end
    chk("t5_single_done", 32'(n), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

`ifdef SC_USEQ_SINGLESTEP_EN
    for (int i = 0; i < 4; i++) load(i, mk(0, 0, i + 1));
    load(4, mk(7, 0, 0));
    step_in = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ss_idle_alu", 32'(alu), 32'd0); chk("ss_busy", 32'(busy), 32'd1);
      tick();
      step_in = 1'b1; #1;
      chk("ss_alu", 32'(alu), 32'(k + 1)); chk("ss_pc", 32'(pc), 32'(k));
      tick();
      step_in = 1'b0;
    end
    tick(); tick();
    step_in = 1'b1; tick();
    chk("ss_done", 32'(done), 32'd1);
    tick();
`endif

    // Randomized traffic
    for (int i = 0; i < DEPTH; i++) load(i, rnd_uw());
    for (int c = 0; c < 3000; c++) begin
      ovf_n = 1'($urandom); cy_n = 1'($urandom); neg_n = 1'($urandom); z_n = 1'($urandom);
      start = ($urandom_range(0, 9) < 3);
      step_in = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 199) == 0);
      wr = !rst && ($urandom_range(0, 9) == 0);
      waddr = 5'($urandom); wr_uw = rnd_uw(); wdata = pack(wr_uw);
      tick();
    end
    rst = 1'b0; wr = 1'b0; start = 1'b0; step_in = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
